// File: rtl/qk_score_serializer_pkg.sv
// Shared types and default sizing for the QK score serializer.
package self_attention_pkg;
  localparam int WIDTH_OUT          = 8;
  localparam int CHUNK_SIZE         = 2;
  localparam int NUM_CORES_A_Qn_KnT = 1;
  localparam int NUM_CORES_B_Qn_KnT = 1;
  localparam int TOTAL_MODULES_LP_Q = 1;
  localparam int TOTAL_INPUT_W      = 4;

  localparam int QK_LANE_W = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A_Qn_KnT *
                             NUM_CORES_B_Qn_KnT * TOTAL_MODULES_LP_Q;
  localparam int QK_SER_LANES = TOTAL_INPUT_W;

  typedef logic [QK_LANE_W-1:0] qk_lane_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;
endpackage

// File: rtl/qk_score_serializer_if.sv
// Vector-in / lane-out bus of the QK score serializer.
// QK_SER_DROP_CNT_EN adds the out_drop_cnt signal.
interface qk_score_serializer_if #(
  parameter int LANE_W    = 16,
  parameter int NUM_LANES = 4,
  localparam int IDX_W    = $clog2(NUM_LANES)
);
  logic              in_valid;
  logic [LANE_W-1:0] in_data [NUM_LANES];
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [IDX_W-1:0]  out_lane_idx;
  logic              out_first;
  logic              out_last;
  logic              clear_ovf;
  logic              out_overflow;
  logic              out_busy;
`ifdef QK_SER_DROP_CNT_EN
  logic [15:0]       out_drop_cnt;
`endif

  modport slave (
    input  in_valid, in_data, out_ready, clear_ovf,
`ifdef QK_SER_DROP_CNT_EN
    output out_drop_cnt,
`endif
    output out_valid, out_data, out_lane_idx, out_first, out_last,
    output out_overflow, out_busy
  );

  modport master (
    output in_valid, in_data, out_ready, clear_ovf,
`ifdef QK_SER_DROP_CNT_EN
    input  out_drop_cnt,
`endif
    input  out_valid, out_data, out_lane_idx, out_first, out_last,
    input  out_overflow, out_busy
  );
endinterface

// File: rtl/qk_score_serializer_bank.sv
// One ping-pong bank: NUM_LANES x LANE_W storage, full flag and lane read mux.
module qk_pingpong_bank #(
  parameter int LANE_W    = 16,
  parameter int NUM_LANES = 4,
  localparam int IDX_W    = $clog2(NUM_LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr_full,
  input  logic [LANE_W-1:0] wr_data [NUM_LANES],
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              full,
  output logic [LANE_W-1:0] rd_data
);
  logic [LANE_W-1:0] mem [NUM_LANES];

  // Contents are don't-care after reset; only the flag is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem <= wr_data;
  end

  // A refill in the same cycle as the release keeps the bank full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        full <= 1'b0;
    else if (wr_en)    full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/qk_score_serializer.sv
// Captures bridge vectors into two banks and replays them one lane per beat.
// QK_SER_DROP_CNT_EN adds a saturating 16-bit dropped-vector counter.
module qk_score_serializer
  import self_attention_pkg::*;
#(
  parameter int LANE_W    = QK_LANE_W,
  parameter int NUM_LANES = QK_SER_LANES,
  localparam int IDX_W    = $clog2(NUM_LANES)
) (
  input logic                  clk,
  input logic                  rst_n,
  qk_score_serializer_if.slave bus
);
  // state     | meaning
  // OCC_EMPTY | no bank holds a vector
  // OCC_ONE   | one bank holds a vector
  // OCC_TWO   | both banks hold vectors, next input drops unless a bank frees
  occ_t             occ;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] lane_idx;
  logic             overflow;
  logic [1:0]       full;
  logic [LANE_W-1:0] rd_data [2];

  logic hs, last_lane, rel, release_now, capture, drop;

  assign hs          = bus.out_valid && bus.out_ready;
  assign last_lane   = (lane_idx == IDX_W'(NUM_LANES - 1));
  assign rel         = hs && last_lane;
  assign release_now = rel && (rd_bank == wr_bank);
  assign capture     = bus.in_valid && (!full[wr_bank] || release_now);
  assign drop        = bus.in_valid && !capture;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    qk_pingpong_bank #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (capture && (wr_bank == 1'(b))),
      .clr_full (rel && (rd_bank == 1'(b))),
      .wr_data  (bus.in_data),
      .rd_idx   (lane_idx),
      .full     (full[b]),
      .rd_data  (rd_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= OCC_EMPTY;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      lane_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) wr_bank <= ~wr_bank;
      if (hs) begin
        lane_idx <= last_lane ? '0 : lane_idx + 1'b1;
        if (last_lane) rd_bank <= ~rd_bank;
      end
      if (drop)               overflow <= 1'b1;
      else if (bus.clear_ovf) overflow <= 1'b0;
      case (occ)
        OCC_EMPTY: if (capture) occ <= OCC_ONE;
        OCC_ONE: begin
          if (capture && !rel)      occ <= OCC_TWO;
          else if (!capture && rel) occ <= OCC_EMPTY;
        end
        OCC_TWO:   if (!capture && rel) occ <= OCC_ONE;
        default:   occ <= OCC_EMPTY;
      endcase
    end
  end

`ifdef QK_SER_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (bus.clear_ovf) begin
      drop_cnt <= '0;
    end
  end

  assign bus.out_drop_cnt = drop_cnt;
`endif

  assign bus.out_valid    = full[rd_bank];
  assign bus.out_data     = rd_bank ? rd_data[1] : rd_data[0];
  assign bus.out_lane_idx = lane_idx;
  assign bus.out_first    = full[rd_bank] && (lane_idx == '0);
  assign bus.out_last     = full[rd_bank] && last_lane;
  assign bus.out_overflow = overflow;
  assign bus.out_busy     = full[0] | full[1];
endmodule

// File: tb/tb_qk_score_serializer.sv
// Bench for qk_score_serializer: queue-level reference model plus directed literal checks.
module tb_qk_score_serializer;
  import self_attention_pkg::*;
  localparam int LW = 16;
  localparam int NL = 4;

  typedef logic [LW-1:0] vec_t [NL];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qk_score_serializer_if #(.LANE_W(LW), .NUM_LANES(NL)) bus ();

  qk_score_serializer #(.LANE_W(LW), .NUM_LANES(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two whole vectors and the lane being offered.
  vec_t mq[$];
  int   m_lane;
  bit   m_ovf;
  int   m_drops;

  always @(posedge clk or negedge rst_n) begin
    bit hs, pop, cap, drp;
    if (!rst_n) begin
      mq.delete();
      m_lane  = 0;
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      hs  = (mq.size() > 0) && bus.out_ready;
      pop = hs && (m_lane == NL - 1);
      cap = bus.in_valid && ((mq.size() < 2) || pop);
      drp = bus.in_valid && !cap;
      if (hs) m_lane = pop ? 0 : m_lane + 1;
      if (pop) void'(mq.pop_front());
      if (cap) mq.push_back(bus.in_data);
      if (drp) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end else if (bus.clear_ovf) begin
        m_ovf   = 0;
        m_drops = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit v;
    if (rst_n) begin
      v = (mq.size() > 0);
      chk("m_out_valid", bus.out_valid, v);
      chk("m_out_busy", bus.out_busy, v);
      chk("m_out_first", bus.out_first, v && m_lane == 0);
      chk("m_out_last", bus.out_last, v && m_lane == NL - 1);
      chk("m_out_overflow", bus.out_overflow, m_ovf);
      if (v) begin
        chk("m_out_data", bus.out_data, mq[0][m_lane]);
        chk("m_out_lane_idx", bus.out_lane_idx, m_lane);
      end
`ifdef QK_SER_DROP_CNT_EN
      chk("m_out_drop_cnt", bus.out_drop_cnt, m_drops);
`endif
    end
  end

  function automatic vec_t mk(input logic [LW-1:0] a, b, c, d);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Drive inputs for one cycle (called just after a falling edge), return at the next falling edge.
  task automatic step(input bit v, input vec_t d, input bit r, input bit c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.clear_ovf = c;
    @(negedge clk);
  endtask

  vec_t z, v0, va, vb, vc, vd, vr;
  logic [LW-1:0] exp_b [8];
  int k;

  initial begin
    z  = mk(16'h0, 16'h0, 16'h0, 16'h0);
    v0 = mk(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    va = mk(16'hA001, 16'hA002, 16'hA003, 16'hA004);
    vb = mk(16'hB001, 16'hB002, 16'hB003, 16'hB004);
    vc = mk(16'hC001, 16'hC002, 16'hC003, 16'hC004);
    vd = mk(16'hD001, 16'hD002, 16'hD003, 16'hD004);
    bus.in_valid = 0; bus.in_data = z; bus.out_ready = 0; bus.clear_ovf = 0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.out_busy, 0);
    chk("rst_overflow", bus.out_overflow, 0);
    chk("rst_first", bus.out_first, 0);
    chk("rst_last", bus.out_last, 0);
    rst_n = 1;
    @(negedge clk);

    // Single vector, out_ready held high
    step(1, v0, 1, 0);
    chk("single_first", bus.out_first, 1);
    for (int i = 0; i < NL; i++) begin
      chk("single_valid", bus.out_valid, 1);
      chk("single_data", bus.out_data, v0[i]);
      chk("single_last", bus.out_last, i == NL - 1);
      step(0, z, 1, 0);
    end
    chk("single_busy_after", bus.out_busy, 0);

    // Backpressure 1,0,1,0...
    step(1, v0, 0, 0);
    k = 0;
    for (int i = 0; i < 2 * NL; i++) begin
      if (i % 2 == 0) begin
        chk("bp_data", bus.out_data, v0[k]);
        chk("bp_idx", bus.out_lane_idx, k);
        k++;
        step(0, z, 1, 0);
      end else begin
        chk("bp_hold_data", bus.out_data, v0[k]);
        step(0, z, 0, 0);
      end
    end
    chk("bp_beats", k, NL);
    chk("bp_busy_after", bus.out_busy, 0);

    // Overflow: A, B, C back to back with the consumer stalled
    step(1, va, 0, 0);
    step(1, vb, 0, 0);
    step(1, vc, 0, 0);
    chk("ovf_flag", bus.out_overflow, 1);
    chk("ovf_busy", bus.out_busy, 1);
`ifdef QK_SER_DROP_CNT_EN
    chk("ovf_drop_cnt", bus.out_drop_cnt, 1);
`endif
    for (int i = 0; i < NL; i++) begin exp_b[i] = va[i]; exp_b[i+NL] = vb[i]; end
    for (int i = 0; i < 2 * NL; i++) begin
      chk("ovf_drain", bus.out_data, exp_b[i]);
      step(0, z, 1, 0);
    end
    chk("ovf_drain_empty", bus.out_valid, 0);
    step(0, z, 0, 1);
    chk("ovf_cleared", bus.out_overflow, 0);

    // Same-cycle release with both banks full
    step(1, va, 0, 0);
    step(1, vb, 0, 0);
    for (int i = 0; i < NL - 1; i++) step(0, z, 1, 0);
    chk("rel_last_pending", bus.out_last, 1);
    chk("rel_last_data", bus.out_data, 16'hA004);
    step(1, vd, 1, 0);
    chk("rel_no_ovf", bus.out_overflow, 0);
    for (int i = 0; i < NL; i++) begin exp_b[i] = vb[i]; exp_b[i+NL] = vd[i]; end
    for (int i = 0; i < 2 * NL; i++) begin
      chk("rel_order", bus.out_data, exp_b[i]);
      step(0, z, 1, 0);
    end
    chk("rel_busy_after", bus.out_busy, 0);

    // Reset mid-drain, asserted between clock edges
    step(1, va, 1, 0);
    step(0, z, 1, 0);
    step(0, z, 1, 0);
    chk("mid_lane_before", bus.out_lane_idx, 2);
    bus.out_ready = 0;
    #2 rst_n = 0;
    #1 chk("mid_async_valid", bus.out_valid, 0);
    chk("mid_async_busy", bus.out_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid_after_valid", bus.out_valid, 0);
    chk("mid_after_busy", bus.out_busy, 0);
    step(1, v0, 0, 0);
    chk("mid_restart_data", bus.out_data, 16'h0011);
    chk("mid_restart_idx", bus.out_lane_idx, 0);
    step(0, z, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < NL; j++) vr[j] = LW'($urandom);
      step(($urandom_range(0, 3) == 0), vr, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3 * NL; i++) step(0, z, 1, 0);
    chk("rand_drained", bus.out_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
